// File: rtl/flash_mem_responder.sv
// flash_mem_responder: NOR-flash device responder for the controller's parallel
// flash bus. Decodes JEDEC unlock/command write cycles, serves reads from an
// internal 2^MEM_AW x 16 array and runs timed program / sector / chip erase with
// RY_BYn_o low while busy.
// Optional feature: define FLASH_STATUS_POLL_EN to make reads during program or
// erase return DQ7/DQ6 status instead of 16'hFFFF.
module flash_mem_responder #(
    parameter int MEM_AW      = 10,
    parameter int SECTOR_AW   = 6,
    parameter int PROG_CYCLES = 16,
    parameter int READ_LAT    = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        CEn_i,
    input  logic        WEn_i,
    input  logic        OEn_i,
    input  logic        BYTEn_i,
    input  logic        RSTn_i,
    input  logic [22:0] addr_i,
    input  logic [15:0] dq_i,
    output logic [15:0] dq_o,
    output logic        dq_oe_o,
    output logic        RY_BYn_o
);

    // Registered address keeps A10..A0 for unlock decode plus the array index bits.
    localparam int AW_R = (MEM_AW > 11) ? MEM_AW : 11;
    localparam int CW   = (MEM_AW + 1 > $clog2(PROG_CYCLES) + 1) ? MEM_AW + 1
                                                                 : $clog2(PROG_CYCLES) + 1;
    localparam int RCW  = (READ_LAT < 2) ? 1 : $clog2(READ_LAT + 1);
    localparam int SW   = MEM_AW - SECTOR_AW;

    localparam logic [CW-1:0]  C_INIT_LAST = CW'((1 << MEM_AW) - 1);
    localparam logic [CW-1:0]  C_CHIP_LEN  = CW'(1 << MEM_AW);
    localparam logic [CW-1:0]  C_SEC_LEN   = CW'(1 << SECTOR_AW);
    localparam logic [CW-1:0]  C_PROG_LAST = CW'(PROG_CYCLES - 1);
    localparam logic [RCW-1:0] C_RL        = RCW'(READ_LAT);
    localparam logic [RCW-1:0] C_RL_M1     = RCW'(READ_LAT - 1);

    typedef enum logic [3:0] {
        S_INIT,
        S_READ,
        S_U1,
        S_U2,
        S_E3,
        S_E4,
        S_E5,
        S_PGM_DATA,
        S_PROGRAM,
        S_ERASE_SEC,
        S_ERASE_CHIP
    } state_t;

    // Registered bus inputs
    logic            r_cen;
    logic            r_wen;
    logic            r_wen_d;
    logic            r_oen;
    logic            r_byten;
    logic            r_rstn;
    logic [AW_R-1:0] r_addr;
    logic [15:0]     r_dq;

    // Command FSM and operation operands
    state_t          r_state;
    state_t          w_state_nxt;
    logic [CW-1:0]   r_cnt;
    logic [CW-1:0]   w_cnt_nxt;
    logic            w_lat_prog;
    logic            w_lat_sec;
    logic [MEM_AW-1:0] r_paddr;
    logic [15:0]     r_pdata;
    logic            r_pbyte;
    logic            r_phi;
    logic [SW-1:0]   r_sector;

    // Decode
    logic            w_wr;
    logic [7:0]      w_cmd;
    logic            w_ua1;
    logic            w_ua2;
    logic            w_busy;

    // Array
    logic [15:0]       r_mem [0:(1 << MEM_AW) - 1];
    logic              w_mem_we;
    logic [MEM_AW-1:0] w_mem_wa;
    logic [15:0]       w_mem_wd;
    logic [15:0]       w_prog_cur;
    logic [15:0]       w_prog_word;
    logic [15:0]       w_arr_rd;
    logic [15:0]       w_rd_word;

    // Read path
    logic [RCW-1:0]  r_rd_cnt;

    logic            w_unused_addr;
    assign w_unused_addr = ^addr_i[22:AW_R];

    // Sample every bus input once; all decode works on these registered copies
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_cen   <= 1'b1;
            r_wen   <= 1'b1;
            r_wen_d <= 1'b1;
            r_oen   <= 1'b1;
            r_byten <= 1'b1;
            r_rstn  <= 1'b1;
            r_addr  <= '0;
            r_dq    <= '0;
        end else begin
            r_cen   <= CEn_i;
            r_wen   <= WEn_i;
            r_wen_d <= r_wen;
            r_oen   <= OEn_i;
            r_byten <= BYTEn_i;
            r_rstn  <= RSTn_i;
            r_addr  <= addr_i[AW_R-1:0];
            r_dq    <= dq_i;
        end
    end

    // A write cycle completes on the sampled WEn rising edge with the chip selected.
    // In x8 mode the unlock address is A10..A-1, with A-1 carried on DQ15.
    assign w_wr   = ~r_cen & ~r_wen_d & r_wen;
    assign w_cmd  = r_dq[7:0];
    assign w_ua1  = r_byten ? (r_addr[10:0] == 11'h555) : ({r_addr[10:0], r_dq[15]} == 12'hAAA);
    assign w_ua2  = r_byten ? (r_addr[10:0] == 11'h2AA) : ({r_addr[10:0], r_dq[15]} == 12'h555);
    assign w_busy = (r_state == S_INIT) || (r_state == S_PROGRAM) ||
                    (r_state == S_ERASE_SEC) || (r_state == S_ERASE_CHIP);

    // FSM state register, op counter and latched program/erase operands
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state  <= S_INIT;
            r_cnt    <= '0;
            r_paddr  <= '0;
            r_pdata  <= '0;
            r_pbyte  <= 1'b0;
            r_phi    <= 1'b0;
            r_sector <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_lat_prog) begin
                r_paddr <= r_addr[MEM_AW-1:0];
                r_pdata <= r_dq;
                r_pbyte <= ~r_byten;
                r_phi   <= r_dq[15];
            end
            if (w_lat_sec) begin
                r_sector <= r_addr[MEM_AW-1:SECTOR_AW];
            end
        end
    end

    // Next-state: device reset aborts everything except the power-up fill;
    // busy states run their counters and ignore bus writes
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_lat_prog  = 1'b0;
        w_lat_sec   = 1'b0;
        if (r_state != S_INIT && !r_rstn) begin
            w_state_nxt = S_READ;
            w_cnt_nxt   = '0;
        end else begin
            case (r_state)
                S_INIT: begin
                    if (r_cnt == C_INIT_LAST) begin
                        w_state_nxt = S_READ;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end
                S_PROGRAM: begin
                    if (r_cnt == C_PROG_LAST) begin
                        w_state_nxt = S_READ;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end
                S_ERASE_SEC: begin
                    if (r_cnt == C_SEC_LEN) begin
                        w_state_nxt = S_READ;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end
                S_ERASE_CHIP: begin
                    if (r_cnt == C_CHIP_LEN) begin
                        w_state_nxt = S_READ;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end
                default: begin
                    if (w_wr) begin
                        w_state_nxt = S_READ;
                        w_cnt_nxt   = '0;
                        if (w_cmd != 8'hF0) begin
                            case (r_state)
                                S_READ: if (w_ua1 && w_cmd == 8'hAA) w_state_nxt = S_U1;
                                S_U1:   if (w_ua2 && w_cmd == 8'h55) w_state_nxt = S_U2;
                                S_U2: begin
                                    if (w_ua1 && w_cmd == 8'hA0) w_state_nxt = S_PGM_DATA;
                                    else if (w_ua1 && w_cmd == 8'h80) w_state_nxt = S_E3;
                                end
                                S_E3:   if (w_ua1 && w_cmd == 8'hAA) w_state_nxt = S_E4;
                                S_E4:   if (w_ua2 && w_cmd == 8'h55) w_state_nxt = S_E5;
                                S_E5: begin
                                    if (w_cmd == 8'h30) begin
                                        w_state_nxt = S_ERASE_SEC;
                                        w_lat_sec   = 1'b1;
                                    end else if (w_ua1 && w_cmd == 8'h10) begin
                                        w_state_nxt = S_ERASE_CHIP;
                                    end
                                end
                                S_PGM_DATA: begin
                                    w_state_nxt = S_PROGRAM;
                                    w_lat_prog  = 1'b1;
                                end
                                default: ;
                            endcase
                        end
                    end
                end
            endcase
        end
    end

    // Ready/busy is a Moore output of the state
    always_comb begin
        RY_BYn_o = ~w_busy;
    end

    // Program value: bits can only clear; x8 touches only the byte selected by A-1
    always_comb begin
        w_prog_cur = r_mem[r_paddr];
        if (!r_pbyte) begin
            w_prog_word = w_prog_cur & r_pdata;
        end else if (r_phi) begin
            w_prog_word = {w_prog_cur[15:8] & r_pdata[7:0], w_prog_cur[7:0]};
        end else begin
            w_prog_word = {w_prog_cur[15:8], w_prog_cur[7:0] & r_pdata[7:0]};
        end
    end

    // Array write port: init fill, one-shot program, erase sweeps (gated off on abort)
    always_comb begin
        w_mem_we = 1'b0;
        w_mem_wa = '0;
        w_mem_wd = 16'hFFFF;
        if (r_state == S_INIT || r_rstn) begin
            case (r_state)
                S_INIT: begin
                    w_mem_we = 1'b1;
                    w_mem_wa = r_cnt[MEM_AW-1:0];
                end
                S_PROGRAM: begin
                    if (r_cnt == '0) begin
                        w_mem_we = 1'b1;
                        w_mem_wa = r_paddr;
                        w_mem_wd = w_prog_word;
                    end
                end
                S_ERASE_SEC: begin
                    if (r_cnt != C_SEC_LEN) begin
                        w_mem_we = 1'b1;
                        w_mem_wa = {r_sector, r_cnt[SECTOR_AW-1:0]};
                    end
                end
                S_ERASE_CHIP: begin
                    if (r_cnt != C_CHIP_LEN) begin
                        w_mem_we = 1'b1;
                        w_mem_wa = r_cnt[MEM_AW-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

    // Array storage, deliberately not reset
    always_ff @(posedge clk_i) begin
        if (w_mem_we) begin
            r_mem[w_mem_wa] <= w_mem_wd;
        end
    end

`ifdef FLASH_STATUS_POLL_EN
    logic r_oen_d;
    logic r_toggle;

    // DQ6 toggle bit flips on every new read access (sampled OEn falling edge)
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_oen_d  <= 1'b1;
            r_toggle <= 1'b0;
        end else begin
            r_oen_d <= r_oen;
            if (r_oen_d && !r_oen && !r_cen) begin
                r_toggle <= ~r_toggle;
            end
        end
    end
`endif

    // Read data: array word (x8 returns the A-1 byte on [7:0]); busy gives status or FFFF
    always_comb begin
        w_arr_rd = r_mem[r_addr[MEM_AW-1:0]];
        if (w_busy) begin
`ifdef FLASH_STATUS_POLL_EN
            if (r_state == S_INIT) begin
                w_rd_word = 16'hFFFF;
            end else begin
                w_rd_word = {8'h00, (r_state == S_PROGRAM) ? ~r_pdata[7] : 1'b0, r_toggle, 6'h00};
            end
`else
            w_rd_word = 16'hFFFF;
`endif
        end else if (!r_byten) begin
            w_rd_word = {8'h00, r_dq[15] ? w_arr_rd[15:8] : w_arr_rd[7:0]};
        end else begin
            w_rd_word = w_arr_rd;
        end
    end

    // Read path: drive DQ after READ_LAT sampled cycles of CEn/OEn low; WEn low,
    // deselect or device reset drop the drive enable next cycle
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_rd_cnt <= '0;
            dq_oe_o  <= 1'b0;
            dq_o     <= '0;
        end else if (!r_rstn || r_cen || r_oen || !r_wen) begin
            r_rd_cnt <= '0;
            dq_oe_o  <= 1'b0;
        end else begin
            if (r_rd_cnt != C_RL) begin
                r_rd_cnt <= r_rd_cnt + 1'b1;
            end
            if (r_rd_cnt >= C_RL_M1) begin
                dq_oe_o <= 1'b1;
            end
            dq_o <= w_rd_word;
        end
    end

endmodule

// File: tb/tb_flash_mem_responder.sv
// Directed bench for flash_mem_responder (default build, status polling off).
module tb_flash_mem_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        CEn;
    logic        WEn;
    logic        OEn;
    logic        BYTEn;
    logic        RSTn;
    logic [22:0] addr;
    logic [15:0] dq_in;
    logic [15:0] dq_out;
    logic        dq_oe;
    logic        ry;

    int n_asserts = 0;
    int n_fails   = 0;
    logic [15:0] sb_q[$];

    always #5 clk = ~clk;

    flash_mem_responder #(
        .MEM_AW(10),
        .SECTOR_AW(6),
        .PROG_CYCLES(16),
        .READ_LAT(2)
    ) dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .CEn_i   (CEn),
        .WEn_i   (WEn),
        .OEn_i   (OEn),
        .BYTEn_i (BYTEn),
        .RSTn_i  (RSTn),
        .addr_i  (addr),
        .dq_i    (dq_in),
        .dq_o    (dq_out),
        .dq_oe_o (dq_oe),
        .RY_BYn_o(ry)
    );

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_write(input logic [22:0] a, input logic [15:0] d);
        @(negedge clk);
        addr = a; dq_in = d; OEn = 1'b1; CEn = 1'b0; WEn = 1'b0;
        @(negedge clk);
        WEn = 1'b1;
        @(negedge clk);
        CEn = 1'b1;
    endtask

    task automatic program16(input logic [22:0] a, input logic [15:0] d);
        do_write(23'h555, 16'h00AA);
        do_write(23'h2AA, 16'h0055);
        do_write(23'h555, 16'h00A0);
        do_write(a, d);
    endtask

    task automatic erase_prefix();
        do_write(23'h555, 16'h00AA);
        do_write(23'h2AA, 16'h0055);
        do_write(23'h555, 16'h0080);
        do_write(23'h555, 16'h00AA);
        do_write(23'h2AA, 16'h0055);
    endtask

    // lat: negedges until RY goes low; len: negedges RY stays low
    task automatic busy_measure(output int lat, output int len);
        lat = 0;
        len = 0;
        while (ry === 1'b1 && lat < 8) begin
            @(negedge clk);
            lat++;
        end
        while (ry === 1'b0 && len < 3000) begin
            len++;
            @(negedge clk);
        end
    endtask

    task automatic count_low(input int n, output int c);
        c = 0;
        repeat (n) begin
            @(negedge clk);
            if (ry !== 1'b1) c++;
        end
    endtask

    task automatic do_read(input logic [22:0] a, input logic am1, output logic [15:0] d, output logic oe);
        int w;
        @(negedge clk);
        addr = a; dq_in = {am1, 15'h0000}; WEn = 1'b1; CEn = 1'b0; OEn = 1'b0;
        w = 0;
        while (dq_oe !== 1'b1 && w < 10) begin
            @(negedge clk);
            w++;
        end
        oe = dq_oe;
        d  = dq_out;
        CEn = 1'b1; OEn = 1'b1;
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic sb_read(input string tag, input logic [22:0] a, input logic am1, input logic [15:0] exp);
        logic [15:0] d;
        logic        oe;
        logic [15:0] e;
        sb_q.push_back(exp);
        do_read(a, am1, d, oe);
        e = sb_q.pop_front();
        chk(tag, {15'h0, oe, d}, {15'h0, 1'b1, e});
    endtask

    initial begin
        int lat;
        int len;
        int c;

        rst = 1'b1; CEn = 1'b1; WEn = 1'b1; OEn = 1'b1; BYTEn = 1'b1; RSTn = 1'b1;
        addr = '0; dq_in = '0;

        // Reset state and power-up fill
        repeat (3) @(negedge clk);
        chk("rst_ry", {31'h0, ry}, 32'h0);
        chk("rst_oe", {31'h0, dq_oe}, 32'h0);
        chk("rst_dq", {16'h0, dq_out}, 32'h0);
        rst = 1'b0;
        len = 0;
        while (ry === 1'b0 && len < 3000) begin
            len++;
            @(negedge clk);
        end
        chk("init_busy_len", len, 1024);
        sb_read("init_rd_000", 23'h000, 1'b0, 16'hFFFF);
        sb_read("init_rd_3ff", 23'h3FF, 1'b0, 16'hFFFF);

        // x16 word program
        program16(23'h012, 16'h1234);
        busy_measure(lat, len);
        chk("prog_lat", lat, 1);
        chk("prog_len", len, 16);
        sb_read("prog_rd", 23'h012, 1'b0, 16'h1234);
        sb_read("alias_hi", 23'h400012, 1'b0, 16'h1234);
        sb_read("alias_a10", 23'h000412, 1'b0, 16'h1234);

        // AND semantics on reprogram
        program16(23'h012, 16'h00FF);
        busy_measure(lat, len);
        sb_read("reprog_and", 23'h012, 1'b0, 16'h0034);

        // x8 program of the high byte (A-1 = 1)
        BYTEn = 1'b0;
        do_write(23'h555, 16'h00AA);
        do_write(23'h2AA, 16'h8055);
        do_write(23'h555, 16'h00A0);
        do_write(23'h030, 16'h8012);
        busy_measure(lat, len);
        chk("x8_prog_len", len, 16);
        sb_read("x8_rd_hi", 23'h030, 1'b1, 16'h0012);
        sb_read("x8_rd_lo", 23'h030, 1'b0, 16'h00FF);
        BYTEn = 1'b1;
        sb_read("x8_rd_word", 23'h030, 1'b0, 16'h12FF);

        // Sector erase of 0x040..0x07F
        program16(23'h040, 16'h0000); busy_measure(lat, len);
        program16(23'h07F, 16'h1111); busy_measure(lat, len);
        program16(23'h080, 16'h2222); busy_measure(lat, len);
        program16(23'h03F, 16'h3333); busy_measure(lat, len);
        erase_prefix();
        do_write(23'h040, 16'h0030);
        busy_measure(lat, len);
        chk("sec_lat", lat, 1);
        chk("sec_len", len, 65);
        sb_read("sec_first", 23'h040, 1'b0, 16'hFFFF);
        sb_read("sec_last", 23'h07F, 1'b0, 16'hFFFF);
        sb_read("sec_above", 23'h080, 1'b0, 16'h2222);
        sb_read("sec_below", 23'h03F, 1'b0, 16'h3333);
        sb_read("sec_other", 23'h012, 1'b0, 16'h0034);

        // Chip erase aborted by RSTn
        program16(23'h3F0, 16'h5555); busy_measure(lat, len);
        erase_prefix();
        do_write(23'h555, 16'h0010);
        @(negedge clk);
        chk("chip_busy", {31'h0, ry}, 32'h0);
        sb_read("busy_read", 23'h3F0, 1'b0, 16'hFFFF);
        repeat (40) @(negedge clk);
        RSTn = 1'b0;
        lat = 0;
        while (ry !== 1'b1 && lat < 8) begin
            @(negedge clk);
            lat++;
        end
        chk("rstn_abort_lat", lat, 2);
        RSTn = 1'b1;
        count_low(20, c);
        chk("rstn_stays_ready", c, 0);
        sb_read("partial_erased", 23'h012, 1'b0, 16'hFFFF);
        sb_read("partial_kept", 23'h3F0, 1'b0, 16'h5555);
        program16(23'h100, 16'hABCD);
        busy_measure(lat, len);
        chk("post_rstn_len", len, 16);
        sb_read("post_rstn_rd", 23'h100, 1'b0, 16'hABCD);

        // Bad second unlock: no program
        do_write(23'h555, 16'h00AA);
        do_write(23'h2AA, 16'h0054);
        do_write(23'h555, 16'h00A0);
        do_write(23'h020, 16'h0000);
        count_low(20, c);
        chk("badunlock_ready", c, 0);
        sb_read("badunlock_rd", 23'h020, 1'b0, 16'hFFFF);

        // F0 returns to read array mid-sequence
        do_write(23'h555, 16'h00AA);
        do_write(23'h2AA, 16'h0055);
        do_write(23'h000, 16'h00F0);
        do_write(23'h021, 16'h0000);
        count_low(20, c);
        chk("f0_ready", c, 0);
        sb_read("f0_rd", 23'h021, 1'b0, 16'hFFFF);

        // Held read: address change, deselect, write-enable override
        @(negedge clk);
        addr = 23'h012; WEn = 1'b1; CEn = 1'b0; OEn = 1'b0;
        repeat (4) @(negedge clk);
        chk("hold_oe", {31'h0, dq_oe}, 32'h1);
        addr = 23'h100;
        repeat (2) @(negedge clk);
        chk("addr_change", {16'h0, dq_out}, {16'h0, 16'hABCD});
        CEn = 1'b1;
        repeat (2) @(negedge clk);
        chk("cen_oe_off", {31'h0, dq_oe}, 32'h0);
        CEn = 1'b0;
        repeat (4) @(negedge clk);
        WEn = 1'b0;
        repeat (2) @(negedge clk);
        chk("wen_oe_off", {31'h0, dq_oe}, 32'h0);
        CEn = 1'b1;
        @(negedge clk);
        WEn = 1'b1; OEn = 1'b1;
        repeat (3) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
        $finish;
    end

endmodule
